// File: rtl/mext_pkg.sv
// mext_pkg: shared state type, instruction encodings and multiplier op-select
// codes for the M-extension multiply issue controller.
package mext_pkg;

    localparam int unsigned XLEN = 32;

    // Issue controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        COOL  = 2'd3
    } mext_state_e;

    localparam logic [6:0] MEXT_FUNCT7 = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    localparam logic [2:0] MULSEL_NONE   = 3'b000;
    localparam logic [2:0] MULSEL_MUL    = 3'b001;
    localparam logic [2:0] MULSEL_MULH   = 3'b010;
    localparam logic [2:0] MULSEL_MULHSU = 3'b011;
    localparam logic [2:0] MULSEL_MULHU  = 3'b100;

    // One cached multiply: key {funct3, rs1, rs2} and its result
    typedef struct packed {
        logic            valid;
        logic [2:0]      funct3;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] result;
    } mext_cache_entry_t;

    // funct3 of a multiply to the multiplier op-select code
    function automatic logic [2:0] mulsel_map(input logic [2:0] funct3);
        logic [2:0] sel;
        unique case (funct3)
            F3_MUL:    sel = MULSEL_MUL;
            F3_MULH:   sel = MULSEL_MULH;
            F3_MULHSU: sel = MULSEL_MULHSU;
            F3_MULHU:  sel = MULSEL_MULHU;
            default:   sel = MULSEL_NONE;
        endcase
        return sel;
    endfunction

    // Op-select code back to funct3, used to tag cache entries
    function automatic logic [2:0] mulsel_to_funct3(input logic [2:0] sel);
        logic [2:0] f3;
        unique case (sel)
            MULSEL_MULH:   f3 = F3_MULH;
            MULSEL_MULHSU: f3 = F3_MULHSU;
            MULSEL_MULHU:  f3 = F3_MULHU;
            default:       f3 = F3_MUL;
        endcase
        return f3;
    endfunction

endpackage

// File: rtl/mext_reuse_cache.sv
// mext_reuse_cache: single-entry result cache for repeated multiplies.
// Only instantiated when MEXT_RESULT_REUSE_EN is defined.
module mext_reuse_cache
    import mext_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            inv,
    input  logic [2:0]      wr_funct3,
    input  logic [XLEN-1:0] wr_rs1,
    input  logic [XLEN-1:0] wr_rs2,
    input  logic [XLEN-1:0] wr_result,
    input  logic [2:0]      lk_funct3,
    input  logic [XLEN-1:0] lk_rs1,
    input  logic [XLEN-1:0] lk_rs2,
    output logic            hit_c,
    output logic [XLEN-1:0] hit_data_c
);

    mext_cache_entry_t entry_q;

    // Entry storage: invalidate wins over a write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= '0;
        end else if (inv) begin
            entry_q.valid <= 1'b0;
        end else if (wr_en) begin
            entry_q.valid  <= 1'b1;
            entry_q.funct3 <= wr_funct3;
            entry_q.rs1    <= wr_rs1;
            entry_q.rs2    <= wr_rs2;
            entry_q.result <= wr_result;
        end
    end

    // Lookup against the current EX-stage instruction
    always_comb begin
        hit_c      = entry_q.valid & (entry_q.funct3 == lk_funct3)
                   & (entry_q.rs1 == lk_rs1) & (entry_q.rs2 == lk_rs2);
        hit_data_c = entry_q.result;
    end

endmodule

// File: rtl/mext_mul_issue.sv
// mext_mul_issue: issue/stall controller between EX and the M-extension
// multiplier. Decodes MUL/MULH/MULHSU/MULHU, drives the multiplier op select
// and operands, waits for its 2-cycle ready, and returns the result as a
// 1-cycle writeback pulse. Between operations the multiplier always sees
// op select NONE with ready low so it returns to its cleared state.
// Optional: MEXT_RESULT_REUSE_EN adds a 1-entry result cache (mext_reuse_cache).
module mext_mul_issue
    import mext_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [6:0]  in_funct7,
    input  logic [2:0]  in_funct3,
    input  logic        in_opcode_op,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [4:0]  in_rd,
    input  logic        flush,
    output logic [2:0]  mulsel,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_ready,
    input  logic [31:0] mul_res,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err
);

    mext_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]       mulsel_d;
    logic [31:0]      mul_a_d, mul_b_d, wb_data_d;
    logic [4:0]       wb_rd_d;
    logic             wb_valid_d, err_d;

    logic             is_mul, can_take, accept, reuse, timeout;
    logic             hit_c;
    logic [31:0]      hit_data_c;

    assign is_mul  = in_valid & in_opcode_op & (in_funct7 == MEXT_FUNCT7) & ~in_funct3[2];
    // Hold EX until the result pulse for this instruction is on the bus
    assign stall   = is_mul & ~wb_valid;
    // A mul that already has its writeback pulse has retired; never take it twice
    assign can_take = (state_q == IDLE) & is_mul & ~flush & ~wb_valid;
    assign accept   = can_take & ~hit_c;
    assign reuse    = can_take & hit_c;
    assign timeout  = (cnt_q == CNT_W'(TIMEOUT));

`ifdef MEXT_RESULT_REUSE_EN
    logic cache_wr, cache_inv;

    // Fill on normal completion, drop on watchdog abort
    assign cache_wr  = (state_q == ISSUE) & ~flush & mul_ready;
    assign cache_inv = (state_q == ISSUE) & ~flush & ~mul_ready & timeout;

    mext_reuse_cache u_cache (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (cache_wr),
        .inv        (cache_inv),
        .wr_funct3  (mulsel_to_funct3(mulsel)),
        .wr_rs1     (mul_a),
        .wr_rs2     (mul_b),
        .wr_result  (mul_res),
        .lk_funct3  (in_funct3),
        .lk_rs1     (in_rs1),
        .lk_rs2     (in_rs2),
        .hit_c      (hit_c),
        .hit_data_c (hit_data_c)
    );
`else
    assign hit_c      = 1'b0;
    assign hit_data_c = '0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: flush, ready and timeout all leave ISSUE through DRAIN
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   if (flush | mul_ready | timeout) state_d = DRAIN;
            DRAIN:   if (!mul_ready) state_d = COOL;
            COOL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next-values: flush beats ready, ready beats the watchdog
    always_comb begin
        mulsel_d   = MULSEL_NONE;
        mul_a_d    = mul_a;
        mul_b_d    = mul_b;
        wb_rd_d    = wb_rd;
        wb_data_d  = wb_data;
        wb_valid_d = 1'b0;
        err_d      = 1'b0;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    mulsel_d = mulsel_map(in_funct3);
                    mul_a_d  = in_rs1;
                    mul_b_d  = in_rs2;
                    wb_rd_d  = in_rd;
                    cnt_d    = '0;
                end else if (reuse) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = hit_data_c;
                    wb_rd_d    = in_rd;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (flush) begin
                    mulsel_d = MULSEL_NONE;
                end else if (mul_ready) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = mul_res;
                end else if (timeout) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = '0;
                    err_d      = 1'b1;
                end else begin
                    mulsel_d = mulsel;
                end
            end
            DRAIN: begin
            end
            COOL: begin
            end
            default: begin
            end
        endcase
    end

    // Registered outputs and watchdog counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mulsel   <= MULSEL_NONE;
            mul_a    <= '0;
            mul_b    <= '0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_valid <= 1'b0;
            err      <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mulsel   <= mulsel_d;
            mul_a    <= mul_a_d;
            mul_b    <= mul_b_d;
            wb_rd    <= wb_rd_d;
            wb_data  <= wb_data_d;
            wb_valid <= wb_valid_d;
            err      <= err_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: doc/mext_mul_issue.md
Name: mext_mul_issue

Overview:
- Issue/stall controller between the EX stage and the M-extension multiplier.
- Decodes MUL/MULH/MULHSU/MULHU from funct7/funct3, latches operands, and drives the multiplier's 3-bit op select and operands.
- Sequences the multiplier's ready/idle protocol, stalls the pipeline, captures the 32-bit result and presents it for writeback.
- Guarantees the multiplier sees op-select = none between operations, so it returns to its idle/cleared state.

Parameters:
- TIMEOUT, 15, max cycles in ISSUE waiting for mul_ready before abort.
- CNT_W, 4, width of the watchdog counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  EX-stage instruction valid.
- in_funct7  in  7  instruction funct7.
- in_funct3  in  3  instruction funct3.
- in_opcode_op  in  1  instruction is OP (R-type) major opcode.
- in_rs1  in  32  rs1 value.
- in_rs2  in  32  rs2 value.
- in_rd  in  5  destination register.
- flush  in  1  kill in-flight EX instruction.
- mulsel  out  3  op select to the multiplier: 000 none, 001 MUL, 010 MULH, 011 MULHSU, 100 MULHU.
- mul_a  out  32  operand a to the multiplier.
- mul_b  out  32  operand b to the multiplier.
- mul_ready  in  1  multiplier result-valid; high for 2 cycles.
- mul_res  in  32  multiplier result.
- stall  out  1  hold the EX stage.
- wb_valid  out  1  1-cycle result-valid pulse.
- wb_rd  out  5  destination register for the result.
- wb_data  out  32  result value.
- err  out  1  1-cycle pulse on watchdog abort.

Behaviour:
- Reset (async): state IDLE. All outputs 0: mulsel=000, mul_a, mul_b, wb_valid, wb_rd, wb_data, err. Watchdog counter 0.
- is_mul = in_valid & in_opcode_op & in_funct7==0000001 & in_funct3[2]==0. funct3 1xx (DIV/REM) is ignored.
- Op-select map from funct3: 000→001, 001→010, 010→011, 011→100.
- stall = is_mul & ~wb_valid (combinational). It also covers a mul presented while the FSM is in DRAIN/COOL.
- mulsel, mul_a, mul_b, wb_* and err are all registered.
- IDLE:
  - if is_mul & ~flush: latch rs1/rs2 into mul_a/mul_b, in_rd into the wb_rd holding register, mulsel=map(funct3); clear the counter; go to ISSUE.
  - Otherwise mulsel=000.
- ISSUE: mulsel held stable; counter increments each cycle.
  - flush: mulsel=000, go to DRAIN, no writeback.
  - Else if mul_ready: wb_data<=mul_res, wb_valid<=1 next cycle, mulsel<=000, go to DRAIN.
  - Else if counter==TIMEOUT: mulsel<=000, err and wb_valid pulse with wb_data=0, go to DRAIN.
  - flush has priority over mul_ready, and mul_ready over the timeout.
- DRAIN: mulsel=000; when mul_ready==0, go to COOL.
- COOL: mulsel=000 for exactly 1 cycle with mul_ready low, so the multiplier clears; then go to IDLE.
- Latency: accept at cycle T → multiplier mul_ready at T+3 → wb_valid at T+4 (stall low at T+4). Back-to-back accept no earlier than T+6.
- wb_valid is high for exactly one cycle per completed, non-flushed op.
- flush outside ISSUE: in IDLE it suppresses acceptance; in DRAIN/COOL it has no effect. A flush arriving the same cycle the wb_valid pulse is registered does not cancel it, since the instruction has already retired.
- rst mid-operation returns to IDLE immediately. mulsel=000 then forces the multiplier to its cleared state.

Optional Feature:
- Macro: MEXT_RESULT_REUSE_EN.
- When defined: a 1-entry cache {valid, funct3, rs1, rs2, result}, written on every normal completion.
  - In IDLE, if is_mul & hit: the multiplier is not issued, wb_valid/wb_data come from the cache at T+1, and the FSM stays in IDLE.
  - The cache is invalidated by rst and by a watchdog abort.
- When not defined: no cache; every mul is issued.

Decomposition:
- Package mext_pkg: FSM state enum {IDLE, ISSUE, DRAIN, COOL}; funct3 constants; MULSEL_* encodings; MEXT_FUNCT7 constant.
- Sub-module mext_reuse_cache holds the optional 1-entry cache, instantiated only under the macro.

Test Plan:
- MUL, rs1=7, rs2=6, rd=5 at T → mulsel=001 at T+1, wb_valid at T+4, wb_data=42, wb_rd=5; stall high T..T+3.
- MULH 0x80000000 × 0x80000000 → wb_data=0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Back-to-back MUL then MULHU → second mulsel assertion no earlier than T+7; mulsel=000 for ≥1 cycle with mul_ready low between them.
- flush at T+2 during ISSUE → no wb_valid; mulsel=000 at T+3; next mul accepted correctly.
- mul_ready tied low → err and wb_valid pulse with wb_data=0 after TIMEOUT cycles in ISSUE; FSM returns to IDLE.
- With MEXT_RESULT_REUSE_EN: repeat MUL 7×6 → wb_valid at T+1 = 42, mulsel stays 000. Then rst → same op is issued to the multiplier again.
